// File: rtl/fpu_pkg.sv
// Shared constants and types for the operand entry block.
// Holds the default debounce length, the entry FSM state encoding
// and the number of byte lanes per 32-bit operand.
package fpu_pkg;

    // 10 ms of stable level at a 100 MHz clock
    localparam int DEBOUNCE_DEFAULT = 1000000;

    // Byte lanes per operand
    localparam int NUM_LANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

endpackage

// File: rtl/operand_entry_if.sv
// Bundle of the operand entry user/downstream signals.
// slave: the operand_entry block (consumes switches/buttons/op_ready, drives operands).
// master: whatever drives the switches and buttons and consumes the operand pair.
interface operand_entry_if;
    logic [7:0]  datain;
    logic [1:0]  seldata;
    logic        selnum;
    logic        datawork;
    logic        save_btn;
    logic        start_btn;
    logic        op_ready;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [3:0]  mask0;
    logic [3:0]  mask1;
    logic        op_valid;
    logic        err;

    modport slave (
        input  datain, seldata, selnum, datawork, save_btn, start_btn, op_ready,
        output n0, n1, mask0, mask1, op_valid, err
    );

    modport master (
        output datain, seldata, selnum, datawork, save_btn, start_btn, op_ready,
        input  n0, n1, mask0, mask1, op_valid, err
    );
endinterface

// File: rtl/button_conditioner.sv
// Turns a raw bouncing push-button into a single one-cycle press pulse.
// Ports: clock/reset; raw (asynchronous button level); pulse (one cycle per accepted press).
// Latency: the pulse is visible after the (DEBOUNCE_CYCLES+2)th edge following the first high sample.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = fpu_pkg::DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_q;
    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            count   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            // Any return to the accepted level restarts the stability count,
            // so a bounce shorter than DEBOUNCE_CYCLES never flips the level.
            if (sync_b == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync_b;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/operand_entry.sv
// Byte-wise entry of two 32-bit operands from switches, handed off to a downstream FSM.
// Ports: clock/reset; bus (slave modport) carries switches, buttons, op_ready and the operand outputs.
// A start with all 8 lanes written offers the pair (op_valid) until op_ready; otherwise err pulses.
module operand_entry
    import fpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    operand_entry_if.slave  bus
);
    logic                 save_pulse;
    logic                 start_pulse;
    state_t               state, state_next;
    logic [31:0]          n0_next, n1_next;
    logic [NUM_LANES-1:0] mask0_next, mask1_next;
    logic                 err_next;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save (
        .clock (clock),
        .reset (reset),
        .raw   (bus.save_btn),
        .pulse (save_pulse)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock (clock),
        .reset (reset),
        .raw   (bus.start_btn),
        .pulse (start_pulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus.n0       <= '0;
            bus.n1       <= '0;
            bus.mask0    <= '0;
            bus.mask1    <= '0;
            bus.op_valid <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_next;
            bus.n0       <= n0_next;
            bus.n1       <= n1_next;
            bus.mask0    <= mask0_next;
            bus.mask1    <= mask1_next;
            bus.op_valid <= (state_next == VALID);
            bus.err      <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        n0_next    = bus.n0;
        n1_next    = bus.n1;
        mask0_next = bus.mask0;
        mask1_next = bus.mask1;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (save_pulse && bus.datawork) begin
                    if (bus.selnum) begin
                        n1_next[{bus.seldata, 3'b000} +: 8] = bus.datain;
                        mask1_next[bus.seldata]             = 1'b1;
                    end else begin
                        n0_next[{bus.seldata, 3'b000} +: 8] = bus.datain;
                        mask0_next[bus.seldata]             = 1'b1;
                    end
                end
                // Check the masks after this cycle's write so a save that
                // fills the last lane can coincide with the start press.
                if (start_pulse) begin
                    if ((&mask0_next) && (&mask1_next)) begin
                        state_next = VALID;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            VALID: begin
                if (bus.op_ready) begin
                    state_next = IDLE;
                    mask0_next = '0;
                    mask1_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;
    import fpu_pkg::*;

    localparam int DB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    operand_entry_if bus();

    operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        sel;
        logic [1:0]  lane;
        logic [7:0]  din;
        logic        dw;
        logic [31:0] en0;
        logic [31:0] en1;
        logic [3:0]  em0;
        logic [3:0]  em1;
    } vec_t;

    typedef struct {
        logic [31:0] n0;
        logic [31:0] n1;
        logic [3:0]  m0;
        logic [3:0]  m1;
    } exp_t;

    vec_t vt [9];
    exp_t sb [$];
    exp_t e;

    int n_vec  = 0;
    int n_miss = 0;
    int err_cyc = 0;
    int ov_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock, then sample away from the edge and accumulate pulse counts.
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.err === 1'b1) err_cyc++;
        if (bus.op_valid === 1'b1) ov_cyc++;
    endtask

    task automatic set_sw(input logic sel, input logic [1:0] lane, input logic [7:0] din, input logic dw);
        bus.selnum   = sel;
        bus.seldata  = lane;
        bus.datain   = din;
        bus.datawork = dw;
    endtask

    // Clean press: held well past the debounce, then released and allowed to settle.
    task automatic press_save();
        @(negedge clock);
        bus.save_btn = 1'b1;
        repeat (DB + 6) tick();
        @(negedge clock);
        bus.save_btn = 1'b0;
        repeat (DB + 6) tick();
    endtask

    task automatic press_start();
        @(negedge clock);
        bus.start_btn = 1'b1;
        repeat (DB + 6) tick();
        @(negedge clock);
        bus.start_btn = 1'b0;
        repeat (DB + 6) tick();
    endtask

    initial begin
        // sel, lane, din, dw, expected n0, n1, mask0, mask1 (cumulative)
        vt[0] = '{1'b0, 2'd0, 8'h11, 1'b1, 32'h00A50011, 32'h00000000, 4'b0101, 4'b0000};
        vt[1] = '{1'b0, 2'd1, 8'h22, 1'b0, 32'h00A50011, 32'h00000000, 4'b0101, 4'b0000};
        vt[2] = '{1'b0, 2'd1, 8'h22, 1'b1, 32'h00A52211, 32'h00000000, 4'b0111, 4'b0000};
        vt[3] = '{1'b0, 2'd2, 8'h33, 1'b1, 32'h00332211, 32'h00000000, 4'b0111, 4'b0000};
        vt[4] = '{1'b0, 2'd3, 8'h44, 1'b1, 32'h44332211, 32'h00000000, 4'b1111, 4'b0000};
        vt[5] = '{1'b1, 2'd0, 8'h55, 1'b1, 32'h44332211, 32'h00000055, 4'b1111, 4'b0001};
        vt[6] = '{1'b1, 2'd1, 8'h66, 1'b1, 32'h44332211, 32'h00006655, 4'b1111, 4'b0011};
        vt[7] = '{1'b1, 2'd2, 8'h77, 1'b1, 32'h44332211, 32'h00776655, 4'b1111, 4'b0111};
        vt[8] = '{1'b1, 2'd3, 8'h88, 1'b1, 32'h44332211, 32'h88776655, 4'b1111, 4'b1111};

        bus.save_btn  = 1'b0;
        bus.start_btn = 1'b0;
        bus.op_ready  = 1'b0;
        set_sw(1'b0, 2'd0, 8'h00, 1'b0);

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_n0", bus.n0, 32'h0);
        chk("rst_n1", bus.n1, 32'h0);
        chk("rst_masks", {24'h0, bus.mask0, bus.mask1}, 32'h0);
        chk("rst_valid_err", {30'h0, bus.op_valid, bus.err}, 32'h0);
        reset = 1'b0;

        // Bouncing save button: never stable long enough
        set_sw(1'b0, 2'd1, 8'hEE, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bus.save_btn = i[1];
        end
        @(negedge clock);
        bus.save_btn = 1'b0;
        repeat (DB + 6) tick();
        chk("bounce_n0", bus.n0, 32'h0);
        chk("bounce_n1", bus.n1, 32'h0);
        chk("bounce_masks", {24'h0, bus.mask0, bus.mask1}, 32'h0);

        // Clean press latency: sampling edge is k=0, the write lands on k=DB+3
        set_sw(1'b0, 2'd2, 8'hA5, 1'b1);
        @(negedge clock);
        bus.save_btn = 1'b1;
        for (int k = 0; k <= DB + 3; k++) begin
            tick();
            if (k < DB + 3) begin
                chk($sformatf("lat_n0_k%0d", k), bus.n0, 32'h0);
            end else begin
                chk("lat_n0_write", bus.n0, 32'h00A50000);
                chk("lat_mask0_write", {28'h0, bus.mask0}, 32'h4);
            end
        end
        @(negedge clock);
        bus.save_btn = 1'b0;
        repeat (DB + 6) tick();
        chk("hold_one_write_mask0", {28'h0, bus.mask0}, 32'h4);

        // Table of lane writes through the scoreboard
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                // Start with mask1 incomplete; op_ready high early must not matter
                bus.op_ready = 1'b1;
                err_cyc = 0;
                ov_cyc  = 0;
                press_start();
                chk("incomplete_err_cycles", err_cyc, 1);
                chk("incomplete_op_valid", ov_cyc, 0);
                bus.op_ready = 1'b0;
            end
            set_sw(vt[i].sel, vt[i].lane, vt[i].din, vt[i].dw);
            sb.push_back('{vt[i].en0, vt[i].en1, vt[i].em0, vt[i].em1});
            err_cyc = 0;
            press_save();
            e = sb.pop_front();
            chk($sformatf("vec%0d_n0", i), bus.n0, e.n0);
            chk($sformatf("vec%0d_n1", i), bus.n1, e.n1);
            chk($sformatf("vec%0d_masks", i), {24'h0, bus.mask0, bus.mask1}, {24'h0, e.m0, e.m1});
            chk($sformatf("vec%0d_err", i), err_cyc, 0);
        end

        // Complete start: VALID held while op_ready low, released on op_ready
        @(negedge clock);
        bus.start_btn = 1'b1;
        for (int k = 0; k <= DB + 3; k++) tick();
        chk("start_op_valid", {31'h0, bus.op_valid}, 32'h1);
        @(negedge clock);
        bus.start_btn = 1'b0;
        ov_cyc = 0;
        err_cyc = 0;
        for (int k = 0; k < 10; k++) tick();
        chk("valid_held_cycles", ov_cyc, 10);
        chk("valid_no_err", err_cyc, 0);
        @(negedge clock);
        bus.op_ready = 1'b1;
        tick();
        chk("ack_op_valid", {31'h0, bus.op_valid}, 32'h0);
        chk("ack_masks", {24'h0, bus.mask0, bus.mask1}, 32'h0);
        chk("ack_n0", bus.n0, 32'h44332211);
        chk("ack_n1", bus.n1, 32'h88776655);
        @(negedge clock);
        bus.op_ready = 1'b0;

        // Fill 7 lanes, then save of the last lane together with start
        for (int i = 0; i < 7; i++) begin
            set_sw(i >= 4, 2'(i % 4), 8'(i < 4 ? 8'h10 + i : 8'h20 + i - 4), 1'b1);
            press_save();
        end
        set_sw(1'b1, 2'd3, 8'h23, 1'b1);
        @(negedge clock);
        bus.save_btn  = 1'b1;
        bus.start_btn = 1'b1;
        for (int k = 0; k <= DB + 3; k++) begin
            tick();
            if (k == DB + 2) chk("same_cycle_pre_valid", {31'h0, bus.op_valid}, 32'h0);
        end
        chk("same_cycle_valid", {31'h0, bus.op_valid}, 32'h1);
        chk("same_cycle_n1", bus.n1, 32'h23222120);
        chk("same_cycle_n0", bus.n0, 32'h13121110);
        @(negedge clock);
        bus.save_btn  = 1'b0;
        bus.start_btn = 1'b0;
        repeat (DB + 6) tick();

        // Save during VALID is ignored
        set_sw(1'b0, 2'd0, 8'hFF, 1'b1);
        err_cyc = 0;
        press_save();
        chk("valid_save_n0", bus.n0, 32'h13121110);
        chk("valid_save_n1", bus.n1, 32'h23222120);
        chk("valid_save_still_valid", {31'h0, bus.op_valid}, 32'h1);
        chk("valid_save_err", err_cyc, 0);
        @(negedge clock);
        bus.op_ready = 1'b1;
        tick();
        @(negedge clock);
        bus.op_ready = 1'b0;

        // Reset in the middle of a save debounce
        set_sw(1'b0, 2'd0, 8'h77, 1'b1);
        @(negedge clock);
        bus.save_btn = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_n0", bus.n0, 32'h0);
        chk("midrst_n1", bus.n1, 32'h0);
        chk("midrst_masks", {24'h0, bus.mask0, bus.mask1}, 32'h0);
        @(negedge clock);
        bus.save_btn = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        err_cyc = 0;
        ov_cyc  = 0;
        repeat (20) tick();
        chk("postrst_n0", bus.n0, 32'h0);
        chk("postrst_masks", {24'h0, bus.mask0, bus.mask1}, 32'h0);
        chk("postrst_pulses", err_cyc + ov_cyc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
